rv32_mod_fetch: RTL and testbench

- Instruction fetch stage for the rv32imc single-stage core.
- Owns the program counter and fetches RV32 and RVC instructions over a 32-bit word-aligned memory interface.
- Assembles 32-bit instructions that straddle a word boundary and presents one instruction at a time to decode.
- Consumes the branch unit's taken decision and target to select the next PC.

---
 rtl/rv32_mod_fetch.sv | 187 ++++++++++++++++++
 tb/tb_rv32_mod_fetch.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_mod_fetch.sv
// Instruction fetch stage: owns the PC, fetches RV32/RVC instructions over a
// word-aligned memory port, reassembles straddling instructions, and redirects on branches.
module rv32_mod_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_is_c,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    FETCH_LO,
    FETCH_HI,
    HOLD,
    FAULT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [29:0] tag_q, tag_d;
  logic        buf_valid_q, buf_valid_d;
  logic [15:0] lo_q, lo_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic        is_c_q, is_c_d;
  logic        fault_q, fault_d;

  logic [15:0] ack_half;
  logic [31:0] next_pc;
  logic        hit;
  logic [15:0] buf_half;
  logic        buf_half_c;
  logic        retire;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_d       = buf_q;
    tag_d       = tag_q;
    buf_valid_d = buf_valid_q;
    lo_d        = lo_q;
    req_d       = req_q;
    addr_d      = addr_q;
    instr_d     = instr_q;
    ipc_d       = ipc_q;
    is_c_d      = is_c_q;
    fault_d     = fault_q;

    ack_half   = pc_q[1] ? imem_rdata[31:16] : imem_rdata[15:0];
    retire     = (state_q == HOLD) && instr_ready;
    next_pc    = branch_taken ? branch_target : pc_q + (is_c_q ? 32'd2 : 32'd4);
    // A taken branch discards the buffer even when its tag would match.
    hit        = buf_valid_q && !branch_taken && (tag_q == next_pc[31:2]);
    buf_half   = next_pc[1] ? buf_q[31:16] : buf_q[15:0];
    buf_half_c = (buf_half[1:0] != 2'b11);

    case (state_q)
      FETCH_LO: begin
        if (!req_q) begin
          req_d  = 1'b1;
          addr_d = {pc_q[31:2], 2'b00};
        end else if (imem_ack) begin
          buf_d       = imem_rdata;
          tag_d       = pc_q[31:2];
          buf_valid_d = 1'b1;
          ipc_d       = pc_q;
          if (ack_half[1:0] != 2'b11) begin
            instr_d = {16'h0000, ack_half};
            is_c_d  = 1'b1;
            req_d   = 1'b0;
            state_d = HOLD;
          end else if (!pc_q[1]) begin
            instr_d = imem_rdata;
            is_c_d  = 1'b0;
            req_d   = 1'b0;
            state_d = HOLD;
          end else begin
            lo_d    = ack_half;
            addr_d  = {pc_q[31:2] + 30'd1, 2'b00};
            state_d = FETCH_HI;
          end
        end
      end

      FETCH_HI: begin
        if (!req_q) begin
          req_d  = 1'b1;
          addr_d = {pc_q[31:2] + 30'd1, 2'b00};
        end else if (imem_ack) begin
          instr_d     = {imem_rdata[15:0], lo_q};
          is_c_d      = 1'b0;
          ipc_d       = pc_q;
          buf_d       = imem_rdata;
          tag_d       = pc_q[31:2] + 30'd1;
          buf_valid_d = 1'b1;
          req_d       = 1'b0;
          state_d     = HOLD;
        end
      end

      HOLD: begin
        if (retire) begin
          pc_d = next_pc;
          if (branch_taken) begin
            buf_valid_d = 1'b0;
          end
          if (next_pc[0]) begin
            fault_d = 1'b1;
            state_d = FAULT;
          end else if (hit && (buf_half_c || !next_pc[1])) begin
            instr_d = buf_half_c ? {16'h0000, buf_half} : buf_q;
            is_c_d  = buf_half_c;
            ipc_d   = next_pc;
          end else if (hit && next_pc[1]) begin
            lo_d    = buf_half;
            req_d   = 1'b1;
            addr_d  = {next_pc[31:2] + 30'd1, 2'b00};
            state_d = FETCH_HI;
          end else begin
            req_d   = 1'b1;
            addr_d  = {next_pc[31:2], 2'b00};
            state_d = FETCH_LO;
          end
        end
      end

      FAULT: begin
        req_d = 1'b0;
      end

      default: state_d = FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= FETCH_LO;
      pc_q        <= RESET_PC;
      buf_q       <= '0;
      tag_q       <= '0;
      buf_valid_q <= 1'b0;
      lo_q        <= '0;
      req_q       <= 1'b0;
      addr_q      <= '0;
      instr_q     <= '0;
      ipc_q       <= '0;
      is_c_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_q       <= buf_d;
      tag_q       <= tag_d;
      buf_valid_q <= buf_valid_d;
      lo_q        <= lo_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      instr_q     <= instr_d;
      ipc_q       <= ipc_d;
      is_c_q      <= is_c_d;
      fault_q     <= fault_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = (state_q == HOLD);
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_is_c  = is_c_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_rv32_mod_fetch.sv
// Randomized bench for rv32_mod_fetch: instruction stream and memory traffic are
// predicted from a byte-addressed memory image and a last-fetched-word model.
module tb_rv32_mod_fetch;

  localparam logic [31:0] RPC = 32'h0000_0080;
  localparam int unsigned N_INSTR = 300;

  logic        clk;
  logic        rstn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_is_c;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        fetch_fault;

  rv32_mod_fetch #(.RESET_PC(RPC)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_is_c   (instr_is_c),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .fetch_fault  (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // 256-byte memory image, aliased across the whole address space
  logic [31:0] mem [64];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return mem[a[7:2]];
  endfunction

  function automatic logic [15:0] mem_half(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[7:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Reference model: expected instruction at m_pc and the word addresses it costs
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_is_c;
  logic        m_buf_valid;
  logic [31:0] m_buf_word;
  logic [31:0] exp_addr [$];

  task automatic model_next();
    logic [15:0] lo;
    logic [31:0] w0, w1;
    logic        whole;
    lo     = mem_half(m_pc);
    m_is_c = (lo[1:0] != 2'b11);
    m_instr = m_is_c ? {16'h0000, lo} : {mem_half(m_pc + 32'd2), lo};
    w0    = {m_pc[31:2], 2'b00};
    w1    = w0 + 32'd4;
    whole = m_is_c || !m_pc[1];
    if (m_buf_valid && m_buf_word == w0 && whole) begin
      // served from the last fetched word
    end else if (m_buf_valid && m_buf_word == w0) begin
      exp_addr.push_back(w1);
      m_buf_word = w1;
    end else begin
      exp_addr.push_back(w0);
      if (whole) m_buf_word = w0;
      else begin
        exp_addr.push_back(w1);
        m_buf_word = w1;
      end
    end
    m_buf_valid = 1'b1;
  endtask

  logic [15:0] h;
  logic [31:0] ea;
  logic        mem_pending, ack_given, retire_pend, done;
  logic        bt_s;
  logic [31:0] tgt_s;
  int unsigned delay, hold_left, n_retired, stall, r;

  initial begin
    for (int i = 0; i < 64; i++) begin
      for (int k = 0; k < 2; k++) begin
        h = 16'($urandom);
        if ($urandom_range(0, 1) == 0) h[1:0] = 2'($urandom_range(0, 2));
        else h[1:0] = 2'b11;
        mem[i][k*16 +: 16] = h;
      end
    end
    mem[0]    = 32'h0005_4501;
    mem[1]    = 32'h0093_0001;
    mem[2]    = 32'h1234_0050;
    mem[6'h20] = 32'h0050_0093;

    rstn = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
    instr_ready = 1'b0; branch_taken = 1'b0; branch_target = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_req", imem_req, 0);
    check_eq("rst_valid", instr_valid, 0);
    check_eq("rst_instr", instr, 0);
    check_eq("rst_pc", instr_pc, 0);
    check_eq("rst_is_c", instr_is_c, 0);
    check_eq("rst_fault", fetch_fault, 0);

    imem_ack = 1'b0;
    rstn = 1'b1;
    m_pc = RPC; m_buf_valid = 1'b0; m_buf_word = '0;
    model_next();
    mem_pending = 0; ack_given = 0; retire_pend = 0; done = 0;
    bt_s = 0; tgt_s = '0; delay = 0; hold_left = 0; n_retired = 0; stall = 0; ea = '0;
    @(negedge clk);
    check_eq("first_req", imem_req, 1);

    while (!done && stall < 200) begin
      if (retire_pend) begin
        retire_pend = 0;
        stall = 0;
        n_retired++;
        if (bt_s) begin
          m_pc = tgt_s;
          m_buf_valid = 1'b0;
        end else begin
          m_pc = m_pc + (m_is_c ? 32'd2 : 32'd4);
        end
        if (m_pc[0]) begin
          check_eq("fault_flag", fetch_fault, 1);
          check_eq("fault_valid", instr_valid, 0);
          check_eq("fault_req", imem_req, 0);
          done = 1;
        end else begin
          model_next();
          if (exp_addr.size() == 0) check_eq("hit_valid", instr_valid, 1);
          else begin
            check_eq("miss_req", imem_req, 1);
            check_eq("miss_novalid", instr_valid, 0);
          end
        end
      end

      if (!done) begin
        if (ack_given) begin
          ack_given = 0;
          mem_pending = 0;
          imem_ack = 1'b0;
          if (exp_addr.size() == 0) check_eq("valid_after_ack", instr_valid, 1);
        end
        imem_rdata = $urandom;
        if (imem_req) begin
          if (!mem_pending) begin
            mem_pending = 1;
            if (exp_addr.size() == 0) begin
              check_eq("unexpected_req", imem_req, 0);
              ea = imem_addr;
            end else begin
              ea = exp_addr.pop_front();
              check_eq("req_addr", imem_addr, ea);
            end
            delay = $urandom_range(0, 3);
          end else begin
            check_eq("addr_stable", imem_addr, ea);
          end
          if (delay == 0) begin
            imem_ack = 1'b1;
            imem_rdata = mem_word(ea);
            ack_given = 1;
          end else delay--;
        end else if (mem_pending) begin
          check_eq("req_held", imem_req, 1);
          mem_pending = 0;
        end

        if (instr_valid) begin
          check_eq("instr", instr, m_instr);
          check_eq("instr_pc", instr_pc, m_pc);
          check_eq("instr_is_c", instr_is_c, m_is_c);
          check_eq("hold_no_req", imem_req, 0);
          if (hold_left == 0 && $urandom_range(0, 3) == 0) hold_left = $urandom_range(1, 5);
          if (hold_left == 0) begin
            r = $urandom_range(0, 9);
            bt_s = 1'b1;
            if (n_retired == 0) tgt_s = 32'h0;
            else if (n_retired == N_INSTR - 1) tgt_s = 32'h101;
            else if (r < 2) tgt_s = m_pc + (m_is_c ? 32'd2 : 32'd4);
            else if (r < 4) tgt_s = {24'h0, 7'($urandom_range(0, 127)), 1'b0};
            else if (r == 4) tgt_s = {24'hFF_FFFF, 7'($urandom_range(0, 127)), 1'b0};
            else begin
              bt_s = 1'b0;
              tgt_s = $urandom;
            end
            instr_ready = 1'b1;
            branch_taken = bt_s;
            branch_target = tgt_s;
            retire_pend = 1;
          end else begin
            hold_left--;
            instr_ready = 1'b0;
            branch_taken = 1'($urandom_range(0, 1));
            branch_target = $urandom;
          end
        end else begin
          instr_ready = 1'($urandom_range(0, 1));
          branch_taken = 1'($urandom_range(0, 1));
          branch_target = $urandom;
        end
        stall++;
        @(negedge clk);
      end
    end
    if (stall >= 200) check_eq("stall_timeout", stall, 0);

    // Sticky fault ignores acks and retire attempts
    for (int i = 0; i < 5; i++) begin
      imem_ack = 1'($urandom_range(0, 1));
      instr_ready = 1'b1;
      branch_taken = 1'b1;
      branch_target = 32'h0;
      @(negedge clk);
      check_eq("fault_sticky", fetch_fault, 1);
      check_eq("fault_sticky_valid", instr_valid, 0);
      check_eq("fault_sticky_req", imem_req, 0);
    end

    // Reset in the middle of an outstanding request, with stray acks
    imem_ack = 1'b0; instr_ready = 1'b0; branch_taken = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_eq("rr_req", imem_req, 1);
    check_eq("rr_addr", imem_addr, RPC);
    check_eq("rr_fault_clr", fetch_fault, 0);
    repeat (2) @(negedge clk);
    check_eq("rr_addr_wait", imem_addr, RPC);
    rstn = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check_eq("rr_req_drop", imem_req, 0);
    check_eq("rr_valid", instr_valid, 0);
    check_eq("rr_instr", instr, 0);
    check_eq("rr_is_c", instr_is_c, 0);
    rstn = 1'b1;
    @(negedge clk);
    check_eq("rr_stray_ignored", instr_valid, 0);
    check_eq("rr_req_again", imem_req, 1);
    check_eq("rr_addr_again", imem_addr, RPC);
    imem_rdata = 32'h0050_0093;
    @(negedge clk);
    imem_ack = 1'b0;
    check_eq("rr_valid_after_ack", instr_valid, 1);
    check_eq("rr_instr_val", instr, 32'h0050_0093);
    check_eq("rr_instr_pc", instr_pc, RPC);
    check_eq("rr_instr_is_c", instr_is_c, 0);
    check_eq("rr_req_off", imem_req, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
